// File: rtl/uart_tx_arbiter.sv
// Two-requester byte arbiter in front of a memory-mapped UART transmitter.
// Configures the UART after reset, then forwards one granted byte at a time to UDR.
module uart_tx_arbiter #(
    parameter int unsigned                  BUS_ADDR_DATA_LEN = 8,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] UDR_ADDR          = 'hc1,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] UCSRA_ADDR        = 'hc8,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] UCSRB_ADDR        = 'hc9,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] UCSRC_ADDR        = 'hca,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] UBRRL_ADDR        = 'hcc,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] UBRRH_ADDR        = 'hcd,
    parameter logic [11:0]                  UBRR_VALUE        = 12'd103,
    parameter logic [7:0]                   UCSRC_VALUE       = 8'h06
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req0_valid_i,
    input  logic [7:0]                   req0_data_i,
    output logic                         req0_ready_o,
    input  logic                         req1_valid_i,
    input  logic [7:0]                   req1_data_i,
    output logic                         req1_ready_o,
    output logic [BUS_ADDR_DATA_LEN-1:0] addr_o,
    output logic                         wr_o,
    output logic                         rd_o,
    output logic [7:0]                   bus_o,
    input  logic [7:0]                   bus_i,
    output logic                         init_done_o,
    output logic                         busy_o
);

    typedef enum logic [2:0] {
        INIT_H, INIT_L, INIT_C, INIT_B, IDLE, POLL, WRITE
    } state_t;

    state_t                         r_state, w_state_d;
    logic [BUS_ADDR_DATA_LEN-1:0]   r_addr, w_addr_d;
    logic                           r_wr, w_wr_d;
    logic                           r_rd, w_rd_d;
    logic [7:0]                     r_bus, w_bus_d;
    logic                           r_init_done;
    logic                           r_busy, w_busy_d;
    logic [7:0]                     r_hold, w_hold_d;
    logic                           r_last, w_last_d;
    logic                           w_gnt0, w_gnt1;

    always_comb begin
        w_state_d = r_state;
        w_hold_d  = r_hold;
        w_last_d  = r_last;
        w_gnt0    = 1'b0;
        w_gnt1    = 1'b0;
        unique case (r_state)
            // Reset clears the write strobe, so INIT_H dwells until its own write has gone out.
            INIT_H: if (r_wr) w_state_d = INIT_L;
            INIT_L: w_state_d = INIT_C;
            INIT_C: w_state_d = INIT_B;
            INIT_B: w_state_d = IDLE;
            IDLE: begin
                if (req0_valid_i && (!req1_valid_i || r_last)) begin
                    w_gnt0    = 1'b1;
                    w_hold_d  = req0_data_i;
                    w_last_d  = 1'b0;
                    w_state_d = POLL;
                end else if (req1_valid_i) begin
                    w_gnt1    = 1'b1;
                    w_hold_d  = req1_data_i;
                    w_last_d  = 1'b1;
                    w_state_d = POLL;
                end
            end
            POLL:    if (bus_i[5]) w_state_d = WRITE;
            WRITE:   w_state_d = IDLE;
            default: w_state_d = INIT_H;
        endcase
    end

    // Bus outputs are decoded from the next state so they line up with the state they belong to.
    always_comb begin
        w_wr_d   = 1'b0;
        w_rd_d   = 1'b0;
        w_addr_d = '0;
        w_bus_d  = 8'h00;
        w_busy_d = 1'b0;
        unique case (w_state_d)
            INIT_H: begin
                w_wr_d   = 1'b1;
                w_addr_d = UBRRH_ADDR;
                w_bus_d  = {4'h0, UBRR_VALUE[11:8]};
            end
            INIT_L: begin
                w_wr_d   = 1'b1;
                w_addr_d = UBRRL_ADDR;
                w_bus_d  = UBRR_VALUE[7:0];
            end
            INIT_C: begin
                w_wr_d   = 1'b1;
                w_addr_d = UCSRC_ADDR;
                w_bus_d  = UCSRC_VALUE;
            end
            INIT_B: begin
                w_wr_d   = 1'b1;
                w_addr_d = UCSRB_ADDR;
                w_bus_d  = 8'h08;
            end
            POLL: begin
                w_rd_d   = 1'b1;
                w_addr_d = UCSRA_ADDR;
                w_busy_d = 1'b1;
            end
            WRITE: begin
                w_wr_d   = 1'b1;
                w_addr_d = UDR_ADDR;
                w_bus_d  = r_hold;
                w_busy_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= INIT_H;
            r_addr      <= '0;
            r_wr        <= 1'b0;
            r_rd        <= 1'b0;
            r_bus       <= 8'h00;
            r_init_done <= 1'b0;
            r_busy      <= 1'b0;
            r_hold      <= 8'h00;
            r_last      <= 1'b1;
        end else begin
            r_state     <= w_state_d;
            r_addr      <= w_addr_d;
            r_wr        <= w_wr_d;
            r_rd        <= w_rd_d;
            r_bus       <= w_bus_d;
            r_busy      <= w_busy_d;
            r_hold      <= w_hold_d;
            r_last      <= w_last_d;
            if (w_state_d == IDLE) r_init_done <= 1'b1;
        end
    end

    assign req0_ready_o = w_gnt0;
    assign req1_ready_o = w_gnt1;
    assign addr_o       = r_addr;
    assign wr_o         = r_wr;
    assign rd_o         = r_rd;
    assign bus_o        = r_bus;
    assign init_done_o  = r_init_done;
    assign busy_o       = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic, checked cycle by
// cycle against a transaction-level model of the arbiter/UART handshake.
module tb_uart_tx_arbiter;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b1;
    logic       req0_valid_i = 1'b0, req1_valid_i = 1'b0;
    logic [7:0] req0_data_i = 8'h00, req1_data_i = 8'h00;
    logic       req0_ready_o, req1_ready_o;
    logic [7:0] addr_o;
    logic       wr_o, rd_o;
    logic [7:0] bus_o;
    logic [7:0] bus_i = 8'h00;
    logic       init_done_o, busy_o;

    uart_tx_arbiter dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req0_valid_i (req0_valid_i),
        .req0_data_i  (req0_data_i),
        .req0_ready_o (req0_ready_o),
        .req1_valid_i (req1_valid_i),
        .req1_data_i  (req1_data_i),
        .req1_ready_o (req1_ready_o),
        .addr_o       (addr_o),
        .wr_o         (wr_o),
        .rd_o         (rd_o),
        .bus_o        (bus_o),
        .bus_i        (bus_i),
        .init_done_o  (init_done_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // Model: init writes still owed, whether a byte is held, whether UDRE was seen for it.
    int         m_init;
    bit         m_held, m_udre, m_last;
    logic [7:0] m_byte;
    logic [7:0] init_addr [4] = '{8'hcd, 8'hcc, 8'hca, 8'hc9};
    logic [7:0] init_data [4] = '{8'h00, 8'h67, 8'h06, 8'h08};

    // Observed activity, accumulated from DUT outputs only.
    int         obs_rd = 0;
    int         obs_rdy = 0;
    logic [7:0] obs_udr [$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_init = 0;
        m_held = 1'b0;
        m_udre = 1'b0;
        m_last = 1'b1;
    endtask

    task automatic check_cycle();
        logic [7:0] e_addr, e_bus;
        logic       e_wr, e_rd, e_r0, e_r1, e_done, e_busy;
        bit         win;
        e_addr = 8'h00; e_bus = 8'h00;
        e_wr = 0; e_rd = 0; e_r0 = 0; e_r1 = 0; e_done = 0; e_busy = 0;
        if (m_init < 4) begin
            e_wr   = 1'b1;
            e_addr = init_addr[m_init];
            e_bus  = init_data[m_init];
            m_init++;
        end else begin
            e_done = 1'b1;
            if (!m_held) begin
                if (req0_valid_i || req1_valid_i) begin
                    win    = (req0_valid_i && req1_valid_i) ? !m_last : req1_valid_i;
                    e_r0   = !win;
                    e_r1   = win;
                    m_byte = win ? req1_data_i : req0_data_i;
                    m_last = win;
                    m_held = 1'b1;
                    m_udre = 1'b0;
                end
            end else if (!m_udre) begin
                e_rd   = 1'b1;
                e_addr = 8'hc8;
                e_busy = 1'b1;
                if (bus_i[5]) m_udre = 1'b1;
            end else begin
                e_wr   = 1'b1;
                e_addr = 8'hc1;
                e_bus  = m_byte;
                e_busy = 1'b1;
                m_held = 1'b0;
            end
        end
        chk("wr_o", wr_o, e_wr);
        chk("rd_o", rd_o, e_rd);
        chk("addr_o", addr_o, e_addr);
        chk("bus_o", bus_o, e_bus);
        chk("ready0", req0_ready_o, e_r0);
        chk("ready1", req1_ready_o, e_r1);
        chk("init_done", init_done_o, e_done);
        chk("busy", busy_o, e_busy);
    endtask

    task automatic step(input logic v0, input logic [7:0] d0, input logic v1,
                        input logic [7:0] d1, input logic [7:0] bi);
        @(posedge clk_i);
        #1;
        req0_valid_i = v0; req0_data_i = d0;
        req1_valid_i = v1; req1_data_i = d1;
        bus_i = bi;
        @(negedge clk_i);
        check_cycle();
        obs_rd  += int'(rd_o);
        obs_rdy += int'(req0_ready_o) + int'(req1_ready_o);
        if (wr_o && addr_o == 8'hc1) obs_udr.push_back(bus_o);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && (m_held || m_init < 4); i++) step(0, 8'h00, 0, 8'h00, 8'h20);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wr"}, wr_o, 1'b0);
        chk({tag, "_rd"}, rd_o, 1'b0);
        chk({tag, "_addr"}, addr_o, 8'h00);
        chk({tag, "_bus"}, bus_o, 8'h00);
        chk({tag, "_done"}, init_done_o, 1'b0);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_rdy0"}, req0_ready_o, 1'b0);
        chk({tag, "_rdy1"}, req1_ready_o, 1'b0);
    endtask

    initial begin
        int first_rdy, rd0, n0, u0, nA;

        // Reset with a valid already pending; also covers init masking below.
        #1 rst_ni = 1'b0;
        req0_valid_i = 1'b1; req0_data_i = 8'h3a;
        #2 check_all_zero("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();

        first_rdy = 0;
        for (int i = 1; i <= 6; i++) begin
            step(1, 8'h3a, 0, 8'h00, 8'h20);
            if (req0_ready_o && first_rdy == 0) first_rdy = i;
        end
        chk("init_mask_first_ready_cycle", 8'(first_rdy), 8'd5);
        drain();

        // Single byte
        rd0 = obs_rd; n0 = obs_udr.size();
        step(1, 8'h55, 0, 8'h00, 8'h20);
        chk("single_ready0", req0_ready_o, 1'b1);
        step(0, 8'h00, 0, 8'h00, 8'h20);
        step(0, 8'h00, 0, 8'h00, 8'h20);
        chk("single_poll_cycles", 8'(obs_rd - rd0), 8'd1);
        chk("single_udr_count", 8'(obs_udr.size() - n0), 8'd1);
        if (obs_udr.size() > n0) chk("single_udr_byte", obs_udr[n0], 8'h55);

        // Contention
        n0 = obs_udr.size();
        for (int i = 0; i < 12; i++) step(1, 8'ha0, 1, 8'hb1, 8'h20);
        drain();
        chk("contend_udr_count", 8'(obs_udr.size() - n0), 8'd4);
        nA = 0;
        for (int i = n0; i < obs_udr.size(); i++) begin
            if (obs_udr[i] == 8'ha0) nA++;
            if (i > n0) chk("contend_alternate", 8'(obs_udr[i] != obs_udr[i-1]), 8'd1);
        end
        chk("contend_a0_count", 8'(nA), 8'd2);

        // Back-pressure: 10 polls without UDRE, then UDRE
        step(1, 8'h3c, 0, 8'h00, 8'h00);
        rd0 = obs_rd; n0 = obs_udr.size(); u0 = obs_rdy;
        for (int i = 0; i < 10; i++) begin
            step(1, 8'h3c, 1, 8'h77, 8'h00);
            chk("bp_no_write", 8'(obs_udr.size() - n0), 8'd0);
        end
        step(1, 8'h3c, 1, 8'h77, 8'h20);
        step(1, 8'h3c, 1, 8'h77, 8'h00);
        chk("bp_rd_cycles", 8'(obs_rd - rd0), 8'd11);
        chk("bp_udr_count", 8'(obs_udr.size() - n0), 8'd1);
        chk("bp_no_ready", 8'(obs_rdy - u0), 8'd0);
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
                 ($urandom_range(0, 2) == 0) ? 8'($urandom) | 8'h20 : 8'($urandom) & 8'hdf);
        end
        drain();

        // Reset while polling: held byte must be dropped
        step(1, 8'he7, 0, 8'h00, 8'h00);
        step(0, 8'h00, 0, 8'h00, 8'h00);
        chk("midrst_in_poll", rd_o, 1'b1);
        n0 = obs_udr.size();
        rst_ni = 1'b0;
        #1 check_all_zero("midrst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) step(0, 8'h00, 0, 8'h00, 8'h20);
        chk("midrst_no_udr_write", 8'(obs_udr.size() - n0), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
